// File: rtl/sha256_round_core.sv
// SHA-256 compression core: one round per clock, with the message schedule computed on the fly.
// The K constants come from an external ROM addressed by the registered k_idx.
module sha256_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         init,
    input  logic [511:0] block_in,
    output logic [5:0]   k_idx,
    input  logic [31:0]  k_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] wk_q [8];
    logic [31:0] wk_d [8];
    logic [31:0] hb_q [8];
    logic [31:0] hb_d [8];
    logic [31:0] w_q  [16];
    logic [31:0] w_d  [16];
    logic [31:0] dg_q [8];
    logic [31:0] dg_d [8];

    logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_new;

    // Working registers: wk[0..7] = a..h; w_q[0] always holds W[t].
    always_comb begin
        big_s1 = rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25);
        big_s0 = rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22);
        ch     = (wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]);
        maj    = (wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]);
        t1     = wk_q[7] + big_s1 + ch + k_in + w_q[0];
        t2     = big_s0 + maj;
        w_new  = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
               + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
               + w_q[9] + w_q[0];
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wk_d    = wk_q;
        hb_d    = hb_q;
        w_d     = w_q;
        dg_d    = dg_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int i = 0; i < 8; i++) begin
                        wk_d[i] = init ? IV[i] : dg_q[i];
                        hb_d[i] = init ? IV[i] : dg_q[i];
                    end
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511 - 32 * i -: 32];
                    end
                    t_d     = 6'd0;
                    busy_d  = 1'b1;
                    state_d = StRound;
                end
            end
            StRound: begin
                wk_d[0] = t1 + t2;
                wk_d[1] = wk_q[0];
                wk_d[2] = wk_q[1];
                wk_d[3] = wk_q[2];
                wk_d[4] = wk_q[3] + t1;
                wk_d[5] = wk_q[4];
                wk_d[6] = wk_q[5];
                wk_d[7] = wk_q[6];
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i + 1];
                end
                w_d[15] = w_new;
                t_d     = t_q + 6'd1;
                if (t_q == 6'd63) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                for (int i = 0; i < 8; i++) begin
                    dg_d[i] = hb_q[i] + wk_q[i];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            t_q     <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                wk_q[i] <= 32'd0;
                hb_q[i] <= 32'd0;
                dg_q[i] <= IV[i];
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wk_q    <= wk_d;
            hb_q    <= hb_d;
            w_q     <= w_d;
            dg_q    <= dg_d;
        end
    end

    assign k_idx  = t_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign digest = {dg_q[0], dg_q[1], dg_q[2], dg_q[3], dg_q[4], dg_q[5], dg_q[6], dg_q[7]};

endmodule

// File: tb/tb_sha256_round_core.sv
// Bench for sha256_round_core: a driver pushes expected digests and done times into a queue,
// and a monitor pops and checks them on every done pulse.
module tb_sha256_round_core;

    localparam logic [31:0] KTAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DG_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        128'h61626364626364656364656664656667,
        128'h65666768666768696768696a68696a6b,
        128'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f,
        128'h6d6e6f706e6f70718000000000000000
    };
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         init = 1'b0;
    logic [511:0] block_in = '0;
    logic [5:0]   k_idx;
    logic [31:0]  k_in;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic           chk;
        logic [255:0]   dg;
        longint unsigned t_done;
    } exp_t;

    exp_t sb_q [$];

    always #5 clk = ~clk;

    assign k_in = KTAB[k_idx];

    sha256_round_core dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .init     (init),
        .block_in (block_in),
        .k_idx    (k_idx),
        .k_in     (k_in),
        .busy     (busy),
        .done     (done),
        .digest   (digest)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at %0t, expected none", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_time", 256'($time), 256'(e.t_done));
                if (e.chk) check("digest", digest, e.dg);
            end
        end
    end

    // Drive start so that the next rising edge is E0; called away from a rising edge.
    task automatic run_start(input logic [511:0] blk, input logic ini, input logic push,
                             input logic chk, input logic [255:0] exp);
        start    = 1'b1;
        init     = ini;
        block_in = blk;
        @(posedge clk);
        if (push) sb_q.push_back('{chk, exp, longint'($time) + 655});
        #1;
        start    = 1'b0;
        init     = 1'($urandom);
        block_in = {16{$urandom}};
    endtask

    task automatic wait_done(input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_done: got no done in %0d cycles, expected a done pulse", max_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ndone;
        logic        trace_ok;
        logic [255:0] held;

        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;  // reset must win over start
        @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_kidx", 256'(k_idx), 256'(0));
        check("rst_digest", digest, DG_IV);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // First start after reset chaining from the stored IV.
        run_start(BLK_ABC, 1'b0, 1'b1, 1'b1, DG_ABC);
        wait_done(80);
        @(negedge clk);

        // abc with init=1 plus k_idx/busy trace.
        run_start(BLK_ABC, 1'b1, 1'b1, 1'b1, DG_ABC);
        trace_ok = 1'b1;
        for (int n = 0; n < 65; n++) begin
            @(negedge clk);
            if (k_idx !== 6'(n) || busy !== 1'b1 || done !== 1'b0) trace_ok = 1'b0;
        end
        check("kidx_busy_trace", 256'(trace_ok), 256'(1));
        @(negedge clk);
        check("busy_low_at_done", 256'(busy), 256'(0));
        check("done_after_65", 256'(done), 256'(1));

        // Empty message, then digest must hold while idle and init toggles.
        @(negedge clk);
        run_start(BLK_EMPTY, 1'b1, 1'b1, 1'b1, DG_EMPTY);
        wait_done(80);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            init = ~init;
        end
        check("digest_hold", digest, DG_EMPTY);

        // Two-block message; second block starts in the done cycle of the first.
        run_start(BLK_TWO1, 1'b1, 1'b1, 1'b0, '0);
        wait_done(80);
        run_start(BLK_TWO2, 1'b0, 1'b1, 1'b1, DG_TWO);
        wait_done(80);
        @(negedge clk);

        // Stray start and new block_in mid-computation must be ignored.
        run_start(BLK_ABC, 1'b1, 1'b1, 1'b1, DG_ABC);
        repeat (10) @(posedge clk);
        #1;
        start    = 1'b1;
        init     = 1'b0;
        block_in = BLK_EMPTY;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(80);
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_extra_done", 256'(ndone), 256'(0));

        // Reset at round 30 aborts; nothing queued for it.
        run_start(BLK_EMPTY, 1'b1, 1'b0, 1'b0, '0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_done", 256'(done), 256'(0));
        check("abort_kidx", 256'(k_idx), 256'(0));
        check("abort_digest", digest, DG_IV);
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 256'(ndone), 256'(0));
        run_start(BLK_ABC, 1'b0, 1'b1, 1'b1, DG_ABC);
        wait_done(80);
        held = digest;
        repeat (4) @(negedge clk);
        check("final_digest", held, DG_ABC);

        check("queue_empty", 256'(sb_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
